// File: rtl/cong16_tuantu_pkg.sv
// Shared constants and FSM state type for the nibble-serial adder.
package cong16_tuantu_pkg;

    localparam int NIBBLE_W        = 4;
    localparam int NUM_NIBBLES_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cong16_tuantu_bocong.sv
// 4-bit ripple-carry adder slice used once per cycle by the serial adder.
module bocong
    import cong16_tuantu_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] sum,
    output logic                co
);

    logic [NIBBLE_W:0] carry;

    assign carry[0] = ci;

    generate
        for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_fa
            assign sum[gi]     = x[gi] ^ y[gi] ^ carry[gi];
            assign carry[gi+1] = (x[gi] & y[gi]) | (carry[gi] & (x[gi] ^ y[gi]));
        end
    endgenerate

    assign co = carry[NIBBLE_W];

endmodule

// File: rtl/cong16_tuantu.sv
// Nibble-serial adder: one 4-bit slice per cycle, result published on entry to DONE.
module cong16_tuantu
    import cong16_tuantu_pkg::*;
#(
    parameter int NUM_NIBBLES = NUM_NIBBLES_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [NIBBLE_W*NUM_NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NUM_NIBBLES-1:0] b,
    input  logic                            cin,
    output logic                            busy,
    output logic                            done,
    output logic [NIBBLE_W*NUM_NIBBLES-1:0] s,
    output logic                            cout,
    output logic                            ovf
);

    localparam int W  = NIBBLE_W * NUM_NIBBLES;
    localparam int CW = $clog2(NUM_NIBBLES) + 1;

    state_t          state_reg;
    state_t          state_next;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    res_reg;
    logic [W-1:0]    s_reg;
    logic            carry_reg;
    logic            cout_reg;
    logic            ovf_reg;
    logic            a_msb_reg;
    logic            b_msb_reg;
    logic [CW-1:0]   cnt_reg;

    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_co;
    logic                last_slice;
    logic [W-1:0]        res_shift;

    bocong u_slice (
        .x   (a_reg[NIBBLE_W-1:0]),
        .y   (b_reg[NIBBLE_W-1:0]),
        .ci  (carry_reg),
        .sum (slice_sum),
        .co  (slice_co)
    );

    assign last_slice = (cnt_reg == CW'(NUM_NIBBLES - 1));
    // Slices arrive LSB first, so each new nibble enters at the top and older ones move down.
    assign res_shift  = {slice_sum, res_reg[W-1:NIBBLE_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (last_slice) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            s_reg     <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        a_msb_reg <= a[W-1];
                        b_msb_reg <= b[W-1];
                        res_reg   <= '0;
                        cnt_reg   <= '0;
                    end
                end
                ST_RUN: begin
                    a_reg     <= a_reg >> NIBBLE_W;
                    b_reg     <= b_reg >> NIBBLE_W;
                    carry_reg <= slice_co;
                    res_reg   <= res_shift;
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (last_slice) begin
                        // Operand MSBs were saved at acceptance because a_reg/b_reg are shifted out by now.
                        s_reg    <= res_shift;
                        cout_reg <= slice_co;
                        ovf_reg  <= (a_msb_reg == b_msb_reg) && (slice_sum[NIBBLE_W-1] != a_msb_reg);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_reg != ST_IDLE);
    assign done = (state_reg == ST_DONE);
    assign s    = s_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: doc/cong16_tuantu.md
CONG16_TUANTU -- requirements
Module: cong16_tuantu

Interface
REQ-001 SHALL have parameter NUM_NIBBLES, default 4, number of 4-bit slices per operand (operand width W = 4*NUM_NIBBLES).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin one addition; sampled on the rising edge of clk.
REQ-005 SHALL have port a  input  W  operand A; sampled only on the accepting edge.
REQ-006 SHALL have port b  input  W  operand B; sampled only on the accepting edge.
REQ-007 SHALL have port cin  input  1  carry-in; sampled only on the accepting edge.
REQ-008 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse; marks the first cycle in which the result is valid.
REQ-010 SHALL have port s  output  W  sum.
REQ-011 SHALL have port cout  output  1  carry-out of the MSB slice.
REQ-012 SHALL have port ovf  output  1  two's-complement overflow flag.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 IDLE: if start=1, SHALL latch a, b and cin, clear the slice counter, clear the result register, and go to RUN; otherwise SHALL stay in IDLE.
REQ-015 RUN: each cycle SHALL add the current low nibbles of the A/B shift registers and the carry register through one 4-bit adder slice.
REQ-016 RUN: each cycle SHALL store the slice carry-out into the carry register.
REQ-017 RUN: each cycle SHALL shift the 4-bit slice sum into the top of the result register, shifting existing contents right by 4.
REQ-018 RUN: each cycle SHALL shift the A and B registers right by 4 and increment the slice counter.
REQ-019 RUN SHALL last exactly NUM_NIBBLES cycles; after the last slice, SHALL go to DONE.
REQ-020 DONE SHALL last exactly one cycle, with done=1, and SHALL then go unconditionally to IDLE.
REQ-021 Latency: for start accepted at edge k, done SHALL be high in the cycle after edge k+NUM_NIBBLES (NUM_NIBBLES+1 cycles from acceptance).
REQ-022 s, cout and ovf SHALL update only on entry to DONE, and SHALL hold until the next DONE.
REQ-023 cout SHALL equal the carry register after the final slice.
REQ-024 ovf SHALL equal (a[W-1]==b[W-1]) && (s[W-1]!=a[W-1]), computed from the latched operands.
REQ-025 s and cout together SHALL equal the (W+1)-bit result a+b+cin; no truncation other than ovf semantics.
REQ-026 start SHALL be ignored while busy=1 (RUN or DONE), including during the DONE cycle; latched operands SHALL NOT change.
REQ-027 With start held high continuously, a new addition SHALL be accepted on the first edge in IDLE after DONE, giving a period of NUM_NIBBLES+2 cycles.
REQ-028 Changes on a, b or cin after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-029 rst_n=0 SHALL asynchronously force the FSM to IDLE and clear all operand, result, carry and counter registers.
REQ-030 During reset, outputs SHALL be busy=0, done=0, s=0, cout=0, ovf=0.
REQ-031 Reset mid-RUN or in DONE SHALL abort the operation with no done pulse; the first start after release SHALL behave as from a cold reset.

Structure
REQ-032 A shared package/header SHALL hold NIBBLE_W=4, default NUM_NIBBLES, and the FSM state encoding (IDLE/RUN/DONE as a 2-bit type).
REQ-033 The 4-bit slice SHALL be one instance of the existing 4-bit ripple adder bocong; no other sub-module.
REQ-034 The slice counter SHALL be sized $clog2(NUM_NIBBLES)+1 bits.

Verification
REQ-035 Reset, then start with a=0x0000, b=0x0000, cin=0 -> busy high 5 cycles, done pulse in cycle 5, s=0x0000, cout=0, ovf=0.
REQ-036 a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, cout=1, ovf=0; a=0x1234, b=0x4321, cin=1 -> s=0x5556, cout=0.
REQ-037 a=0x7FFF, b=0x0001, cin=0 -> s=0x8000, cout=0, ovf=1; a=0x8000, b=0x8000 -> s=0x0000, cout=1, ovf=1.
REQ-038 Start a=0x0F0F, b=0x0101, then pulse start with other operands during RUN and DONE -> both ignored; s=0x1010; exactly one done pulse.
REQ-039 Start held high for 20 cycles -> done every 6 cycles; each result matches the operands present at its accepting edge.
REQ-040 Assert rst_n=0 in the 2nd RUN cycle -> outputs zero immediately; no done; the next addition after release is correct.
